// File: rtl/serial_word_driver_if.sv
// Handshake and serial-output bundle between a word producer and serial_word_driver.
interface serial_word_driver_if #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) ();
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] word_in;
  logic             word_valid;
  logic             word_ready;
  logic             data;
  logic             frame;
  logic             busy;
  logic [CW-1:0]    count;

  modport master (
    output word_in, word_valid,
    input  word_ready, data, frame, busy, count
  );

  modport slave (
    input  word_in, word_valid,
    output word_ready, data, frame, busy, count
  );
endinterface

// File: rtl/serial_word_driver.sv
// FIFO-buffered parallel words shifted MSB-first onto a framed single-bit line,
// with a programmable idle gap between consecutive words.
module serial_word_driver #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int GAP   = 1
) (
  input logic                 fast_clk,
  input logic                 reset,
  serial_word_driver_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int BW = $clog2(WIDTH);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             push, pop, have_word;
  logic [WIDTH-1:0] head;

  state_t           state_q;
  logic [BW-1:0]    bit_cnt_q;
  logic [GW-1:0]    gap_cnt_q;
  logic [WIDTH-1:0] shreg_q;
  logic             data_q, frame_q;

  assign have_word      = (count_q != '0);
  assign head           = mem[rd_ptr_q];
  // Ready looks only at occupancy, so a full FIFO refuses a push even when it pops.
  assign bus.word_ready = (count_q < DEPTH_C);
  assign push           = bus.word_valid && bus.word_ready;

  always_comb begin
    pop = 1'b0;
    unique case (state_q)
      S_IDLE:  pop = have_word;
      S_SHIFT: pop = (bit_cnt_q == '0) && (GAP == 0) && have_word;
      S_GAP:   pop = (gap_cnt_q == '0) && have_word;
      default: pop = 1'b0;
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge fast_clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge fast_clk) begin
    if (push) mem[wr_ptr_q] <= bus.word_in;
  end

  // A pop is always the LOAD action, whichever state decided to take the next word.
  always_ff @(posedge fast_clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      shreg_q   <= '0;
      data_q    <= 1'b0;
      frame_q   <= 1'b0;
    end else if (pop) begin
      shreg_q   <= head;
      data_q    <= head[WIDTH-1];
      frame_q   <= 1'b1;
      bit_cnt_q <= BIT_LAST;
      state_q   <= S_SHIFT;
    end else begin
      unique case (state_q)
        S_SHIFT: begin
          if (bit_cnt_q != '0) begin
            shreg_q   <= shreg_q << 1;
            data_q    <= shreg_q[WIDTH-2];
            bit_cnt_q <= bit_cnt_q - 1'b1;
          end else if (GAP > 0) begin
            state_q   <= S_GAP;
            gap_cnt_q <= GAP_LAST;
            frame_q   <= 1'b0;
            data_q    <= 1'b0;
          end else begin
            state_q <= S_IDLE;
            frame_q <= 1'b0;
            data_q  <= 1'b0;
          end
        end
        S_GAP: begin
          if (gap_cnt_q != '0) gap_cnt_q <= gap_cnt_q - 1'b1;
          else                 state_q   <= S_IDLE;
        end
        default: begin
          data_q  <= 1'b0;
          frame_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.data  = data_q;
  assign bus.frame = frame_q;
  assign bus.busy  = (state_q != S_IDLE);
  assign bus.count = count_q;
endmodule

// File: tb/tb_serial_word_driver.sv
// Directed bench for serial_word_driver: GAP=1 instance for most cases, GAP=0 for back-to-back.
module tb_serial_word_driver;
  logic fast_clk = 1'b0;
  logic reset;
  always #5 fast_clk = ~fast_clk;

  serial_word_driver_if #(.WIDTH(4), .DEPTH(4)) bus  ();
  serial_word_driver_if #(.WIDTH(4), .DEPTH(4)) bus0 ();

  serial_word_driver #(.WIDTH(4), .DEPTH(4), .GAP(1)) dut (
    .fast_clk(fast_clk), .reset(reset), .bus(bus)
  );
  serial_word_driver #(.WIDTH(4), .DEPTH(4), .GAP(0)) dut0 (
    .fast_clk(fast_clk), .reset(reset), .bus(bus0)
  );

  typedef struct {
    logic [3:0] word;
    logic [3:0] seq;   // expected serial bits, seq[3] emitted first
  } vec_t;

  int tests = 0;
  int fails = 0;

  logic [3:0] got_q[$];
  logic [3:0] acc;
  int         nb = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge fast_clk);
    #1;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while ((bus.busy || bus.count != 0) && n < 100) begin
      tick;
      n++;
    end
    chk(nm, {bus.busy, bus.count}, 0);
  endtask

  // Reassemble framed words from the GAP=1 instance; data must be 0 outside a frame.
  always @(negedge fast_clk) begin
    if (reset) begin
      nb = 0;
    end else if (bus.frame) begin
      acc = {acc[2:0], bus.data};
      nb++;
      if (nb == 4) begin
        got_q.push_back(acc);
        nb = 0;
      end
    end else begin
      chk("data low while frame low", bus.data, 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t       vecs[5];
    logic [3:0] words[12];
    logic [9:0] fv, dv;
    logic [8:0] fv0, dv0;
    int         idx;
    logic       pushed, saw_full, saw_rec;

    vecs[0] = '{4'b1010, 4'b1010};
    vecs[1] = '{4'b0110, 4'b0110};
    vecs[2] = '{4'b1001, 4'b1001};
    vecs[3] = '{4'b0001, 4'b0001};
    vecs[4] = '{4'b1111, 4'b1111};
    for (int i = 0; i < 12; i++) words[i] = 4'((i * 5 + 1) % 16);

    reset = 1'b1;
    bus.word_in = '0;  bus.word_valid = 1'b0;
    bus0.word_in = '0; bus0.word_valid = 1'b0;
    repeat (3) @(posedge fast_clk);
    #1;
    chk("reset count", bus.count, 0);
    chk("reset frame", bus.frame, 0);
    chk("reset data", bus.data, 0);
    chk("reset busy", bus.busy, 0);
    reset = 1'b0;
    #1;
    chk("ready after reset", bus.word_ready, 1);

    // T1: single words from idle
    for (int v = 0; v < 5; v++) begin
      bus.word_in = vecs[v].word;
      bus.word_valid = 1'b1;
      tick;
      bus.word_valid = 1'b0;
      chk("T1 count after push", bus.count, 1);
      chk("T1 frame before first bit", bus.frame, 0);
      for (int b = 3; b >= 0; b--) begin
        tick;
        chk("T1 frame", bus.frame, 1);
        chk("T1 data", bus.data, vecs[v].seq[b]);
        chk("T1 busy", bus.busy, 1);
      end
      tick;
      chk("T1 gap frame", bus.frame, 0);
      chk("T1 gap busy", bus.busy, 1);
      tick;
      chk("T1 idle busy", bus.busy, 0);
      chk("T1 idle frame", bus.frame, 0);
    end

    // T2: GAP=1 back-to-back pushes
    got_q.delete();
    bus.word_in = 4'b1100; bus.word_valid = 1'b1;
    tick;
    bus.word_in = 4'b0011;
    tick;
    bus.word_valid = 1'b0;
    fv[9] = bus.frame; dv[9] = bus.data;
    for (int c = 8; c >= 0; c--) begin
      tick;
      fv[c] = bus.frame; dv[c] = bus.data;
    end
    chk("T2 frame pattern", fv, 10'b1111011110);
    chk("T2 data pattern", dv, 10'b1100000110);
    wait_idle("T2 idle");
    chk("T2 word count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      chk("T2 word0", got_q[0], 4'b1100);
      chk("T2 word1", got_q[1], 4'b0011);
    end

    // T3: GAP=0 instance, frame stays high across both words
    bus0.word_in = 4'b1111; bus0.word_valid = 1'b1;
    tick;
    bus0.word_in = 4'b0000;
    tick;
    bus0.word_valid = 1'b0;
    fv0[8] = bus0.frame; dv0[8] = bus0.data;
    for (int c = 7; c >= 0; c--) begin
      tick;
      fv0[c] = bus0.frame; dv0[c] = bus0.data;
    end
    chk("T3 frame pattern", fv0, 9'b111111110);
    chk("T3 data pattern", dv0, 9'b111100000);
    chk("T3 idle busy", bus0.busy, 0);

    // T4: continuous producer, FIFO fills and drains
    got_q.delete();
    idx = 0; saw_full = 1'b0; saw_rec = 1'b0;
    for (int cyc = 0; cyc < 200 && idx < 12; cyc++) begin
      bus.word_in = words[idx];
      bus.word_valid = 1'b1;
      pushed = bus.word_ready;
      tick;
      if (pushed) idx++;
      if (bus.count == 3'd4) begin
        saw_full = 1'b1;
        chk("T4 ready low when full", bus.word_ready, 0);
      end else if (saw_full && bus.word_ready) begin
        saw_rec = 1'b1;
      end
    end
    bus.word_valid = 1'b0;
    chk("T4 all pushed", idx, 12);
    chk("T4 reached full", saw_full, 1);
    chk("T4 ready recovered", saw_rec, 1);
    wait_idle("T4 idle");
    chk("T4 word count", got_q.size(), 12);
    for (int i = 0; i < 12 && i < got_q.size(); i++) chk("T4 word order", got_q[i], words[i]);

    // T5: reset mid-word with words queued
    got_q.delete();
    bus.word_in = 4'b1011; bus.word_valid = 1'b1;
    tick;
    bus.word_in = 4'h6; tick;
    bus.word_in = 4'h9; tick;
    bus.word_in = 4'hC; tick;
    bus.word_valid = 1'b0;
    chk("T5 pre-reset count", bus.count, 3);
    chk("T5 pre-reset frame", bus.frame, 1);
    chk("T5 pre-reset data", bus.data, 1);
    reset = 1'b1;
    #1;
    chk("T5 async data", bus.data, 0);
    chk("T5 async frame", bus.frame, 0);
    chk("T5 async count", bus.count, 0);
    chk("T5 async busy", bus.busy, 0);
    tick;
    reset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick;
      chk("T5 no resume frame", bus.frame, 0);
      chk("T5 no resume count", bus.count, 0);
    end
    chk("T5 nothing emitted", got_q.size(), 0);
    bus.word_in = 4'b1001; bus.word_valid = 1'b1;
    tick;
    bus.word_valid = 1'b0;
    tick;
    chk("T5 new word frame", bus.frame, 1);
    chk("T5 new word msb", bus.data, 1);
    wait_idle("T5 idle");
    chk("T5 word count", got_q.size(), 1);
    if (got_q.size() == 1) chk("T5 word", got_q[0], 4'b1001);

    // T6: push attempts while full are dropped
    got_q.delete();
    for (int k = 0; k < 5; k++) begin
      bus.word_in = 4'(k + 1);
      bus.word_valid = 1'b1;
      tick;
    end
    chk("T6 full count", bus.count, 4);
    chk("T6 full ready", bus.word_ready, 0);
    bus.word_in = 4'hE;
    tick;
    chk("T6 blocked count", bus.count, 4);
    tick;
    chk("T6 pop while full count", bus.count, 3);
    bus.word_valid = 1'b0;
    wait_idle("T6 idle");
    chk("T6 word count", got_q.size(), 5);
    for (int i = 0; i < 5 && i < got_q.size(); i++) chk("T6 word order", got_q[i], 4'(i + 1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
